// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, table field selectors and sequencer states
package fpu_pkg;

  localparam int LUT1_W_C = 40;

  typedef enum logic [4:0] {
    OP_ADDF  = 5'd0,
    OP_ADDPP = 5'd1,
    OP_MULF  = 5'd2,
    OP_MULPP = 5'd3,
    OP_NEGF  = 5'd4,
    OP_INVF  = 5'd5,
    OP_INVPP = 5'd6,
    OP_F2I   = 5'd7,
    OP_F2PP  = 5'd8,
    OP_I2F   = 5'd9,
    OP_II2PP = 5'd10,
    OP_PP2F  = 5'd11,
    OP_PP2II = 5'd12
  } op_e;

  localparam logic FMT_FLOAT = 1'b0;
  localparam logic FMT_POSIT = 1'b1;

  // Which byte of which ROM word carries the answer for a lane.
  typedef enum logic [2:0] {
    FLD_SUM,
    FLD_PROD,
    FLD_NEG,
    FLD_INV,
    FLD_TOINT,
    FLD_TOOTHER,
    FLD_FROMINT
  } field_e;

  localparam int LUT2_SUM_LSB     = 8;
  localparam int LUT2_PROD_LSB    = 0;
  localparam int LUT1_NEG_LSB     = 32;
  localparam int LUT1_INV_LSB     = 24;
  localparam int LUT1_TOINT_LSB   = 16;
  localparam int LUT1_TOOTHER_LSB = 8;
  localparam int LUT1_FROMINT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOOK0 = 3'd1,
    ST_LOOK1 = 3'd2,
    ST_FIN   = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  typedef struct packed {
    logic   legal;
    logic   use_lut2;
    logic   fmt;
    field_e field;
    logic   pair;
  } dec_t;

  function automatic logic [7:0] pick_field(
    input field_e              f,
    input logic [15:0]         d2,
    input logic [LUT1_W_C-1:0] d1
  );
    case (f)
      FLD_SUM:     return d2[LUT2_SUM_LSB +: 8];
      FLD_PROD:    return d2[LUT2_PROD_LSB +: 8];
      FLD_NEG:     return d1[LUT1_NEG_LSB +: 8];
      FLD_INV:     return d1[LUT1_INV_LSB +: 8];
      FLD_TOINT:   return d1[LUT1_TOINT_LSB +: 8];
      FLD_TOOTHER: return d1[LUT1_TOOTHER_LSB +: 8];
      FLD_FROMINT: return d1[LUT1_FROMINT_LSB +: 8];
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// rtl/fpu_op_decode.sv - opcode to table-lookup recipe (ROM, format, field, lane count)
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  function automatic dec_t legal_op(
    input logic   use_lut2,
    input logic   fmt,
    input field_e field,
    input logic   pair
  );
    dec_t d;
    d.legal    = 1'b1;
    d.use_lut2 = use_lut2;
    d.fmt      = fmt;
    d.field    = field;
    d.pair     = pair;
    return d;
  endfunction

  always_comb begin
    dec = '{legal: 1'b0, use_lut2: 1'b0, fmt: FMT_FLOAT, field: FLD_SUM, pair: 1'b0};
    case (op)
      OP_W'(OP_ADDF):  dec = legal_op(1'b1, FMT_FLOAT, FLD_SUM,     1'b0);
      OP_W'(OP_ADDPP): dec = legal_op(1'b1, FMT_POSIT, FLD_SUM,     1'b1);
      OP_W'(OP_MULF):  dec = legal_op(1'b1, FMT_FLOAT, FLD_PROD,    1'b0);
      OP_W'(OP_MULPP): dec = legal_op(1'b1, FMT_POSIT, FLD_PROD,    1'b1);
      OP_W'(OP_NEGF):  dec = legal_op(1'b0, FMT_FLOAT, FLD_NEG,     1'b0);
      OP_W'(OP_INVF):  dec = legal_op(1'b0, FMT_FLOAT, FLD_INV,     1'b0);
      OP_W'(OP_INVPP): dec = legal_op(1'b0, FMT_POSIT, FLD_INV,     1'b1);
      OP_W'(OP_F2I):   dec = legal_op(1'b0, FMT_FLOAT, FLD_TOINT,   1'b0);
      OP_W'(OP_F2PP):  dec = legal_op(1'b0, FMT_FLOAT, FLD_TOOTHER, 1'b0);
      OP_W'(OP_I2F):   dec = legal_op(1'b0, FMT_FLOAT, FLD_FROMINT, 1'b0);
      OP_W'(OP_II2PP): dec = legal_op(1'b0, FMT_POSIT, FLD_FROMINT, 1'b1);
      OP_W'(OP_PP2F):  dec = legal_op(1'b0, FMT_POSIT, FLD_TOOTHER, 1'b0);
      OP_W'(OP_PP2II): dec = legal_op(1'b0, FMT_POSIT, FLD_TOINT,   1'b1);
      default:         ;
    endcase
  end

endmodule

// File: rtl/fpu_lut_sequencer.sv
// rtl/fpu_lut_sequencer.sv - runs each FPU op as one or two lookups in the shared ROMs
module fpu_lut_sequencer
  import fpu_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int LUT2_AW = 17,
  parameter int LUT1_AW = 9,
  parameter int LUT1_W  = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [15:0]        in_rd,
  input  logic [15:0]        in_rs,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_result,
  output logic               out_err,
  output logic               busy,
  output logic               lut2_en,
  output logic [LUT2_AW-1:0] lut2_addr,
  input  logic [15:0]        lut2_data,
  output logic               lut1_en,
  output logic [LUT1_AW-1:0] lut1_addr,
  input  logic [LUT1_W-1:0]  lut1_data
);

  state_e      state, state_nx;
  dec_t        dec;
  logic        pair_q, use_lut2_q, fmt_q;
  field_e      field_q;
  logic [7:0]  rd_hi_q, rs_hi_q, lane0_q, field_now;
  logic        accept, issue, issue_lut2, issue_fmt, cap_lane0, cap_final;
  logic [7:0]  issue_a, issue_b;

  fpu_op_decode #(.OP_W(OP_W)) u_decode (
    .op  (in_op),
    .dec (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = dec.legal ? ST_LOOK0 : ST_OUT;
      ST_LOOK0: state_nx = pair_q ? ST_LOOK1 : ST_FIN;
      ST_LOOK1: state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_OUT;
      ST_OUT:   if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Lane0 is issued straight from the request; lane1 comes from the latched upper bytes.
  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_valid  = (state == ST_OUT);
    busy       = (state != ST_IDLE);
    accept     = in_ready && in_valid;
    issue      = 1'b0;
    issue_lut2 = dec.use_lut2;
    issue_fmt  = dec.fmt;
    issue_a    = in_rd[7:0];
    issue_b    = in_rs[7:0];
    if (accept) begin
      issue = dec.legal;
    end else if (state == ST_LOOK0 && pair_q) begin
      issue      = 1'b1;
      issue_lut2 = use_lut2_q;
      issue_fmt  = fmt_q;
      issue_a    = rd_hi_q;
      issue_b    = rs_hi_q;
    end
    cap_lane0 = (state == ST_LOOK1);
    cap_final = (state == ST_FIN);
  end

  assign field_now = pick_field(field_q, lut2_data, lut1_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_q     <= 1'b0;
      use_lut2_q <= 1'b0;
      fmt_q      <= FMT_FLOAT;
      field_q    <= FLD_SUM;
      rd_hi_q    <= '0;
      rs_hi_q    <= '0;
      lane0_q    <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
      lut2_en    <= 1'b0;
      lut2_addr  <= '0;
      lut1_en    <= 1'b0;
      lut1_addr  <= '0;
    end else begin
      lut2_en <= 1'b0;
      lut1_en <= 1'b0;
      if (accept) begin
        pair_q     <= dec.pair;
        use_lut2_q <= dec.use_lut2;
        fmt_q      <= dec.fmt;
        field_q    <= dec.field;
        rd_hi_q    <= in_rd[15:8];
        rs_hi_q    <= in_rs[15:8];
        out_err    <= !dec.legal;
        if (!dec.legal) out_result <= '0;
      end
      if (issue) begin
        if (issue_lut2) begin
          lut2_en   <= 1'b1;
          lut2_addr <= LUT2_AW'({issue_fmt, issue_a, issue_b});
        end else begin
          lut1_en   <= 1'b1;
          lut1_addr <= LUT1_AW'({issue_fmt, issue_a});
        end
      end
      if (cap_lane0) lane0_q <= field_now;
      // For pair ops the last lookup returned is lane1; lane0 was parked a cycle earlier.
      if (cap_final) out_result <= pair_q ? {field_now, lane0_q} : {8'h00, field_now};
    end
  end

endmodule

// File: tb/tb_fpu_lut_sequencer.sv
// tb/tb_fpu_lut_sequencer.sv - scoreboard bench for fpu_lut_sequencer with ROM models
module tb_fpu_lut_sequencer;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [15:0] in_rd = '0;
  logic [15:0] in_rs = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_err;
  logic        busy;
  logic        lut2_en;
  logic [16:0] lut2_addr;
  logic [15:0] lut2_data = '0;
  logic        lut1_en;
  logic [8:0]  lut1_addr;
  logic [39:0] lut1_data = '0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int          e2c[$];
  logic [16:0] e2a[$];
  int          e1c[$];
  logic [8:0]  e1a[$];

  fpu_lut_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy), .lut2_en(lut2_en),
    .lut2_addr(lut2_addr), .lut2_data(lut2_data), .lut1_en(lut1_en), .lut1_addr(lut1_addr),
    .lut1_data(lut1_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    logic [7:0] a, b;
    if (lut2_en) begin
      a = lut2_addr[15:8];
      b = lut2_addr[7:0];
      lut2_data <= {a + b, a ^ b};
    end
    if (lut1_en) begin
      a = lut1_addr[7:0];
      lut1_data <= {a, a + 8'd1, a + 8'd2, a + 8'd3, a + 8'd4};
    end
  end

  always @(negedge clk) begin
    if (lut2_en) begin e2c.push_back(cyc); e2a.push_back(lut2_addr); end
    if (lut1_en) begin e1c.push_back(cyc); e1a.push_back(lut1_addr); end
  end

  function automatic exp_t model(input logic [4:0] op, input logic [15:0] rd, input logic [15:0] rs);
    exp_t e;
    logic [7:0] a0, a1, b0, b1;
    a0 = rd[7:0]; a1 = rd[15:8]; b0 = rs[7:0]; b1 = rs[15:8];
    e.err = 1'b0; e.lat = 3; e.res = '0;
    case (op)
      5'd0:  e.res = {8'h00, a0 + b0};
      5'd1:  begin e.res = {a1 + b1, a0 + b0}; e.lat = 4; end
      5'd2:  e.res = {8'h00, a0 ^ b0};
      5'd3:  begin e.res = {a1 ^ b1, a0 ^ b0}; e.lat = 4; end
      5'd4:  e.res = {8'h00, a0};
      5'd5:  e.res = {8'h00, a0 + 8'd1};
      5'd6:  begin e.res = {a1 + 8'd1, a0 + 8'd1}; e.lat = 4; end
      5'd7:  e.res = {8'h00, a0 + 8'd2};
      5'd8:  e.res = {8'h00, a0 + 8'd3};
      5'd9:  e.res = {8'h00, a0 + 8'd4};
      5'd10: begin e.res = {a1 + 8'd4, a0 + 8'd4}; e.lat = 4; end
      5'd11: e.res = {8'h00, a0 + 8'd3};
      5'd12: begin e.res = {a1 + 8'd2, a0 + 8'd2}; e.lat = 4; end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic clear_logs();
    e2c.delete(); e2a.delete(); e1c.delete(); e1a.delete();
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle N+1.
  task automatic send(input logic [4:0] op, input logic [15:0] rd, input logic [15:0] rs,
                      input bit push, output int n);
    in_op = op; in_rd = rd; in_rs = rs; in_valid = 1'b1;
    n = cyc;
    if (push) sb.push_back(model(op, rd, rs));
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 5'($urandom); in_rd = 16'($urandom); in_rs = 16'($urandom);
  endtask

  task automatic wait_out(input int n, output int lat);
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin lat = cyc - n; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n, lat;
    exp_t e;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle ready=%b busy=%b want 1/0", in_ready, busy); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_ADDF, 16'h0001, 16'h0001, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    n_checks++; if (out_result !== e.res) $display("FAIL reset_pre_result got %h want %h", out_result, e.res); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_result !== 16'h0 || out_err !== 1'b0) $display("FAIL reset_async_out valid=%b result=%h err=%b want 0/0000/0", out_valid, out_result, out_err); else n_pass++;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_async_ready ready=%b busy=%b want 1/0", in_ready, busy); else n_pass++;
    n_checks++; if (lut2_en !== 1'b0 || lut2_addr !== 17'h0 || lut1_en !== 1'b0 || lut1_addr !== 9'h0) $display("FAIL reset_async_lut en2=%b a2=%h en1=%b a1=%h want all 0", lut2_en, lut2_addr, lut1_en, lut1_addr); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_release ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid); else n_pass++;
  endtask

  task automatic test_addf();
    int n, lat;
    exp_t e;
    clear_logs();
    send(OP_ADDF, 16'h0012, 16'h0034, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL addf_latency got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_result !== e.res || out_err !== e.err) $display("FAIL addf_result got %h/%b want %h/%b", out_result, out_err, e.res, e.err); else n_pass++;
    n_checks++; if (!(e2c.size() == 1 && e2c[0] == n + 1 && e2a[0] == 17'h01234)) $display("FAIL addf_lut2 pulses=%0d want 1 at N+1 addr 01234", e2c.size()); else n_pass++;
    n_checks++; if (e1c.size() != 0) $display("FAIL addf_lut1_idle pulses=%0d want 0", e1c.size()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mulpp();
    int n, lat;
    exp_t e;
    clear_logs();
    send(OP_MULPP, 16'h0305, 16'h0102, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL mulpp_latency got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_result !== e.res || out_err !== e.err) $display("FAIL mulpp_result got %h/%b want %h/%b", out_result, out_err, e.res, e.err); else n_pass++;
    n_checks++; if (!(e2c.size() == 2 && e2c[0] == n + 1 && e2c[1] == n + 2)) $display("FAIL mulpp_pulse_timing pulses=%0d want 2 at N+1,N+2", e2c.size()); else n_pass++;
    n_checks++; if (!(e2a.size() == 2 && e2a[0] == 17'h10502 && e2a[1] == 17'h10301)) $display("FAIL mulpp_addr count=%0d want 10502 then 10301", e2a.size()); else n_pass++;
    n_checks++; if (e1c.size() != 0) $display("FAIL mulpp_lut1_idle pulses=%0d want 0", e1c.size()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_invpp();
    int n, lat;
    exp_t e;
    clear_logs();
    send(OP_INVPP, 16'h10FF, 16'hBEEF, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL invpp_latency got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_result !== e.res) $display("FAIL invpp_result got %h want %h", out_result, e.res); else n_pass++;
    n_checks++; if (!(e1a.size() == 2 && e1c[0] == n + 1 && e1a[0] == 9'h1FF && e1a[1] == 9'h110)) $display("FAIL invpp_addr count=%0d want 1FF then 110", e1a.size()); else n_pass++;
    n_checks++; if (e2c.size() != 0) $display("FAIL invpp_lut2_idle pulses=%0d want 0", e2c.size()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int n, lat;
    exp_t e;
    out_ready = 1'b0;
    send(OP_ADDF, 16'h0005, 16'h0007, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = OP_MULF; in_rd = 16'h00FF; in_rs = 16'h00F0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_result !== e.res || in_ready !== 1'b0) $display("FAIL hold_stable cycle %0d valid=%b result=%h ready=%b want 1/%h/0", i, out_valid, out_result, in_ready, e.res); else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold_release ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    n_checks++; if (e2c.size() != 0 || e1c.size() != 0) $display("FAIL hold_ignored_issue pulses=%0d want 0", e2c.size() + e1c.size()); else n_pass++;
    send(OP_MULF, 16'h0003, 16'h0005, 1, n);
    wait_out(n, lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat || out_result !== e.res) $display("FAIL hold_next_op lat=%0d result=%h want %0d/%h", lat, out_result, e.lat, e.res); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int n, lat;
    exp_t e;
    logic [4:0] op;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 5'd13 : 5'h1F;
      clear_logs();
      send(op, 16'hAAAA, 16'h5555, 1, n);
      wait_out(n, lat);
      e = sb.pop_front();
      n_checks++; if (lat !== e.lat) $display("FAIL illegal_latency op=%0d got %0d want %0d", op, lat, e.lat); else n_pass++;
      n_checks++; if (out_result !== e.res || out_err !== e.err) $display("FAIL illegal_result op=%0d got %h/%b want %h/%b", op, out_result, out_err, e.res, e.err); else n_pass++;
      n_checks++; if (e2c.size() != 0 || e1c.size() != 0) $display("FAIL illegal_no_en op=%0d pulses=%0d want 0", op, e2c.size() + e1c.size()); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    bit saw_valid;
    send(OP_ADDPP, 16'h0102, 16'h0304, 0, n);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || lut2_en !== 1'b1) $display("FAIL midop_in_look1 busy=%b en2=%b want 1/1", busy, lut2_en); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || lut2_en !== 1'b0) $display("FAIL midop_reset ready=%b busy=%b en2=%b want 1/0/0", in_ready, busy, lut2_en); else n_pass++;
    clear_logs();
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midop_abandoned saw_valid=%b ready=%b want 0/1", saw_valid, in_ready); else n_pass++;
    n_checks++; if (e2c.size() != 0 || e1c.size() != 0) $display("FAIL midop_no_en pulses=%0d want 0", e2c.size() + e1c.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, lat;
    exp_t e;
    logic [4:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 15));
      send(op, 16'($urandom), 16'($urandom), 1, n);
      wait_out(n, lat);
      e = sb.pop_front();
      n_checks++; if (lat !== e.lat || out_result !== e.res || out_err !== e.err) $display("FAIL b2b op=%0d lat=%0d result=%h err=%b want %0d/%h/%b", op, lat, out_result, out_err, e.lat, e.res, e.err); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drained left=%0d want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addf();
    test_mulpp();
    test_invpp();
    test_hold();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
